// File: rtl/switch_event_arbiter.sv
// Turns debounced switch levels into press / auto-repeat events. Each switch has one
// pending slot, and all pending slots share one valid/ready port through round-robin arbitration.
module switch_event_arbiter #(
    parameter int N_SW          = 4,
    parameter int CNT_W         = 24,
    parameter int REPEAT_DELAY  = 12_000_000,
    parameter int REPEAT_PERIOD = 3_000_000
) (
    input  logic                    sys_clock,
    input  logic                    sys_rst_n,
    input  logic [N_SW-1:0]         sw_level,
    input  logic [N_SW-1:0]         repeat_en,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_SW)-1:0] evt_id,
    output logic                    evt_repeat,
    output logic [N_SW-1:0]         pending,
    output logic [N_SW-1:0]         overrun,
    input  logic                    overrun_clr
);

    localparam int ID_W = $clog2(N_SW);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [0:0]       state;
    logic [N_SW-1:0]  sw_prev;
    logic [N_SW-1:0]  press;
    logic [N_SW-1:0]  tick;
    logic [N_SW-1:0]  pend_type;
    logic [CNT_W-1:0] hold_cnt [N_SW];
    logic [ID_W-1:0]  last_grant;

    logic             handshake;
    logic [N_SW-1:0]  hs_sel;
    logic [N_SW-1:0]  pending_nxt;
    logic [N_SW-1:0]  type_nxt;
    logic [N_SW-1:0]  overrun_nxt;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;
    int               cand;

    assign handshake = evt_valid & evt_ready;

    always_comb begin
        for (int i = 0; i < N_SW; i++) begin
            press[i] = sw_level[i] & ~sw_prev[i];
            tick[i]  = sw_level[i] & repeat_en[i] & ~press[i] & (hold_cnt[i] == TICK_AT);
        end
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sw_prev <= '0;
            for (int i = 0; i < N_SW; i++) hold_cnt[i] <= '0;
        end else begin
            sw_prev <= sw_level;
            for (int i = 0; i < N_SW; i++) begin
                if (press[i] | ~sw_level[i] | ~repeat_en[i])
                    hold_cnt[i] <= '0;
                else if (hold_cnt[i] == TICK_AT)
                    hold_cnt[i] <= RELOAD;
                else
                    hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hs_sel = '0;
        if (handshake) hs_sel[evt_id] = 1'b1;

        pending_nxt = pending;
        type_nxt    = pend_type;
        overrun_nxt = overrun_clr ? '0 : overrun;
        for (int i = 0; i < N_SW; i++) begin
            if (hs_sel[i]) pending_nxt[i] = 1'b0;
            // An event landing on the slot being consumed this cycle refills it instead of overrunning.
            if (press[i] | tick[i]) begin
                if (!pending[i] || hs_sel[i]) begin
                    pending_nxt[i] = 1'b1;
                    type_nxt[i]    = ~press[i];
                end else begin
                    overrun_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N_SW; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_SW) cand = cand - N_SW;
            cand_idx = ID_W'(cand);
            if (!grant_found && pending[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending   <= '0;
            pend_type <= '0;
            overrun   <= '0;
        end else begin
            pending   <= pending_nxt;
            pend_type <= type_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_repeat <= 1'b0;
            last_grant <= ID_W'(N_SW - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        evt_id     <= grant_idx;
                        evt_repeat <= pend_type[grant_idx];
                        evt_valid  <= 1'b1;
                        state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        last_grant <= evt_id;
                        evt_valid  <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed bench for switch_event_arbiter: an age-based event model checked every cycle,
// plus literal expectations on the logged handshake sequence.
module tb_switch_event_arbiter;

    localparam int N = 4;
    localparam int D = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic [3:0] en = '0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;

    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_repeat;
    logic [3:0] pending;
    logic [3:0] overrun;

    switch_event_arbiter #(
        .N_SW(N), .CNT_W(24), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .sys_clock  (clk),
        .sys_rst_n  (rst_n),
        .sw_level   (sw),
        .repeat_en  (en),
        .evt_valid  (evt_valid),
        .evt_ready  (ready),
        .evt_id     (evt_id),
        .evt_repeat (evt_repeat),
        .pending    (pending),
        .overrun    (overrun),
        .overrun_clr(clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: per-switch hold age, one pending slot per switch, round-robin pick.
    logic [3:0] m_prev, m_pend, m_type, m_ovr;
    logic [3:0] n_pend, n_type, n_ovr;
    int         m_age [N];
    logic       m_valid, m_rep;
    logic [1:0] m_id;
    int         m_last;
    logic       m_hs, m_press, m_tick, m_mine, m_found;
    int         m_j;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev  <= '0;
            m_pend  <= '0;
            m_type  <= '0;
            m_ovr   <= '0;
            m_valid <= 1'b0;
            m_id    <= '0;
            m_rep   <= 1'b0;
            m_last  <= N - 1;
            for (int i = 0; i < N; i++) m_age[i] <= 0;
        end else begin
            m_hs   = m_valid && ready;
            n_pend = m_pend;
            n_type = m_type;
            n_ovr  = clr ? 4'b0 : m_ovr;
            for (int i = 0; i < N; i++) begin
                m_press = sw[i] && !m_prev[i];
                m_tick  = sw[i] && en[i] && !m_press && (m_age[i] >= D - 1) &&
                          ((m_age[i] - (D - 1)) % P == 0);
                m_age[i] <= (m_press || !sw[i] || !en[i]) ? 0 : m_age[i] + 1;
                m_mine  = m_hs && (int'(m_id) == i);
                if (m_mine) n_pend[i] = 1'b0;
                if (m_press || m_tick) begin
                    if (!m_pend[i] || m_mine) begin
                        n_pend[i] = 1'b1;
                        n_type[i] = !m_press;
                    end else begin
                        n_ovr[i] = 1'b1;
                    end
                end
            end
            m_prev <= sw;
            m_pend <= n_pend;
            m_type <= n_type;
            m_ovr  <= n_ovr;
            if (m_valid) begin
                if (m_hs) begin
                    m_valid <= 1'b0;
                    m_last  <= int'(m_id);
                end
            end else begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_j = (m_last + k) % N;
                    if (!m_found && m_pend[m_j]) begin
                        m_found = 1'b1;
                        m_valid <= 1'b1;
                        m_id    <= 2'(m_j);
                        m_rep   <= m_type[m_j];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("evt_valid",  {31'b0, evt_valid},  {31'b0, m_valid});
        check("evt_id",     {30'b0, evt_id},     {30'b0, m_id});
        check("evt_repeat", {31'b0, evt_repeat}, {31'b0, m_rep});
        check("pending",    {28'b0, pending},    {28'b0, m_pend});
        check("overrun",    {28'b0, overrun},    {28'b0, m_ovr});
    end

    // Handshake log, taken from the DUT; expectations on it are literal.
    int log_id[$];
    int log_rep[$];
    int log_cyc[$];

    always @(negedge clk) begin
        if (rst_n && evt_valid && ready) begin
            log_id.push_back(int'(evt_id));
            log_rep.push_back(int'(evt_repeat));
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_id.delete();
        log_rep.delete();
        log_cyc.delete();
    endtask

    task automatic check_evt(input string name, input int k, input int id, input int rep,
                             input int off, input int c0);
        if (k >= log_id.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: event %0d missing, got %0d events", name, k, log_id.size());
        end else begin
            check({name, " id"},     log_id[k],        id);
            check({name, " repeat"}, log_rep[k],       rep);
            check({name, " offset"}, log_cyc[k] - c0,  off);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int c0;

    initial begin
        step(3);
        check("reset valid",   {31'b0, evt_valid}, 0);
        check("reset pending", {28'b0, pending},   0);
        check("reset overrun", {28'b0, overrun},   0);
        rst_n = 1'b1;
        step(2);

        // Fairness: all four together, then 0 and 2.
        clear_log();
        c0 = cyc; sw = 4'b1111; ready = 1'b1;
        step(12);
        check("fair count", log_id.size(), 4);
        for (int k = 0; k < 4; k++) check_evt("fair", k, k, 0, 2 + 2 * k, c0);
        sw = 4'b0000; step(3);
        clear_log();
        c0 = cyc; sw = 4'b0101;
        step(8);
        check("pair count", log_id.size(), 2);
        check_evt("pair0", 0, 0, 0, 2, c0);
        check_evt("pair1", 1, 2, 0, 4, c0);
        sw = 4'b0000; step(3);

        // Single press, held long with repeat off.
        clear_log();
        c0 = cyc; sw = 4'b0001;
        step(12);
        check("single count", log_id.size(), 1);
        check_evt("single", 0, 0, 0, 2, c0);
        sw = 4'b0000; step(3);

        // Backpressure and overrun on sw1.
        clear_log();
        ready = 1'b0; sw = 4'b0010;
        step(3);
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("bp valid", {31'b0, evt_valid}, 1);
            check("bp id",    {30'b0, evt_id},    1);
        end
        sw = 4'b0000; step(2);
        sw = 4'b0010; step(2);
        check("bp overrun", {28'b0, overrun}, 32'h2);
        ready = 1'b1;
        step(6);
        check("bp count", log_id.size(), 1);
        check_evt("bp", 0, 1, 0, log_cyc.size() > 0 ? log_cyc[0] - c0 : -1, c0);
        sw = 4'b0000; step(2);

        // Auto-repeat on sw3: press, then repeats at +8, +12, +16.
        clear_log();
        c0 = cyc; en = 4'b1000; sw = 4'b1000;
        step(18);
        sw = 4'b0000;
        step(8);
        check("repeat count", log_id.size(), 4);
        check_evt("rep0", 0, 3, 0, 2,  c0);
        check_evt("rep1", 1, 3, 1, 10, c0);
        check_evt("rep2", 2, 3, 1, 14, c0);
        check_evt("rep3", 3, 3, 1, 18, c0);
        clear_log();
        en = 4'b0000; sw = 4'b1000;
        step(20);
        check("norep count", log_id.size(), 1);
        check_evt("norep", 0, 3, 0, log_cyc.size() > 0 ? log_cyc[0] - c0 : -1, c0);
        sw = 4'b0000; step(3);

        // Overrun set beats clear in the same cycle.
        ready = 1'b0; sw = 4'b0100;
        step(4);
        sw = 4'b0000; step(2);
        sw = 4'b0100; clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("ovr set wins", {28'b0, overrun}, 32'h4);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("ovr cleared", {28'b0, overrun}, 0);
        ready = 1'b1;
        step(4);
        sw = 4'b0000; step(3);

        // Reset in the middle of an offer while sw0 stays held.
        ready = 1'b0; sw = 4'b0001;
        step(4);
        check("pre-reset valid", {31'b0, evt_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async valid",   {31'b0, evt_valid}, 0);
        check("async pending", {28'b0, pending},   0);
        check("async id",      {30'b0, evt_id},    0);
        step(2);
        rst_n = 1'b1;
        clear_log();
        c0 = cyc; ready = 1'b1;
        step(6);
        check("post-reset count", log_id.size(), 1);
        check_evt("post-reset", 0, 0, 0, 2, c0);
        sw = 4'b0000; step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
